// File: rtl/adc_avg_regbank_if.sv
// adc_avg_regbank_if: ADC response stream, I2C slave byte port and sequencer
// CSR signals of the ADC result bank, grouped into one bundle.
// The alarm vector exists only when ADC_THRESH_EN is defined.
interface adc_avg_regbank_if #(
   parameter int NUM_CH = 5,
   parameter int DATA_W = 12
);
   logic              adc_valid;
   logic [4:0]        adc_channel;
   logic [DATA_W-1:0] adc_data;
   logic              adc_endofpacket;
   logic              slave_asserted;
   logic              slave_in_tx_mode;
   logic              slave_tx_request;
   logic [7:0]        slave_rx_buffer;
   logic              slave_rx_available;
   logic [7:0]        slave_tx_buffer;
   logic              seq_csr_address;
   logic              seq_csr_write;
   logic [31:0]       seq_csr_writedata;
   logic              adc_run;
`ifdef ADC_THRESH_EN
   logic [NUM_CH-1:0] alarm;
`endif

   modport slave (
      input  adc_valid, adc_channel, adc_data, adc_endofpacket,
      input  slave_asserted, slave_in_tx_mode, slave_tx_request,
      input  slave_rx_buffer, slave_rx_available,
      output slave_tx_buffer, seq_csr_address, seq_csr_write, seq_csr_writedata,
`ifdef ADC_THRESH_EN
      output alarm,
`endif
      output adc_run
   );

   modport master (
      output adc_valid, adc_channel, adc_data, adc_endofpacket,
      output slave_asserted, slave_in_tx_mode, slave_tx_request,
      output slave_rx_buffer, slave_rx_available,
      input  slave_tx_buffer, seq_csr_address, seq_csr_write, seq_csr_writedata,
`ifdef ADC_THRESH_EN
      input  alarm,
`endif
      input  adc_run
   );
endinterface

// File: rtl/adc_avg_regbank.sv
// adc_avg_regbank: block-averaged ADC result bank behind an I2C slave byte port.
// Results are published to a shadow copy only while no I2C read is in progress,
// so multi-byte reads stay coherent. Optional per-channel threshold alarms are
// built when ADC_THRESH_EN is defined.
module adc_avg_regbank #(
   parameter int                  NUM_CH   = 5,
   parameter int                  DATA_W   = 12,
   parameter logic [5*NUM_CH-1:0] CH_MAP   = {5'd4, 5'd2, 5'd1, 5'd6, 5'd3},
   parameter int                  AVG_LOG2 = 0
) (
   input logic              clk_core,
   input logic              reset_n,
   adc_avg_regbank_if.slave bus
);
   localparam int ACC_W = DATA_W + AVG_LOG2;
   localparam int PKT_W = AVG_LOG2 + 1;
   localparam logic [PKT_W-1:0] PKT_N = PKT_W'(1 << AVG_LOG2);

   logic [1:0]        txr_h_q, rxa_h_q;
   logic              tx_pls_q, rx_pls_q;
   logic [7:0]        config_q, config_d, ptr_q, ptr_d;
   logic [7:0]        cnt_pub_q, cnt_pub_d, tx_buf_q, tx_buf_d;
   logic [3:0]        nbyte_q, nbyte_d;
   logic              valid_q, valid_d, overrun_q, overrun_d, pending_q, pending_d;
   logic              csr_wr_q, csr_wr_d, run_wd_q, run_wd_d;
   logic [PKT_W-1:0]  pkt_q, pkt_d;
   logic [DATA_W-1:0] raw_q [NUM_CH];
   logic [DATA_W-1:0] raw_d [NUM_CH];
   logic [DATA_W-1:0] avg_q [NUM_CH];
   logic [DATA_W-1:0] avg_d [NUM_CH];
   logic [DATA_W-1:0] shadow_q [NUM_CH];
   logic [DATA_W-1:0] shadow_d [NUM_CH];
   logic [ACC_W-1:0]  acc_q [NUM_CH];
   logic [ACC_W-1:0]  acc_d [NUM_CH];
   logic [7:0]        rdata;
   logic              alarm_any;
   logic              rd_en, wr_en, wr_data_en, new_avg, do_pub, blocked;
`ifdef ADC_THRESH_EN
   logic [DATA_W-1:0] thresh_q [NUM_CH];
   logic [DATA_W-1:0] thresh_d [NUM_CH];
   logic [NUM_CH-1:0] alarm_q, alarm_d, alarm_set, alarm_clr;
   assign alarm_any = |alarm_q;
`else
   assign alarm_any = 1'b0;
`endif

   // Edge detectors: 2-flop history, registered pulse for a fixed latency.
   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         txr_h_q  <= '0;
         rxa_h_q  <= '0;
         tx_pls_q <= 1'b0;
         rx_pls_q <= 1'b0;
      end else begin
         txr_h_q  <= {txr_h_q[0], bus.slave_tx_request};
         rxa_h_q  <= {rxa_h_q[0], bus.slave_rx_available};
         tx_pls_q <= txr_h_q[0] & ~txr_h_q[1];
         rx_pls_q <= rxa_h_q[0] & ~rxa_h_q[1];
      end
   end

   // Register-map read mux addressed by the byte pointer.
   always_comb begin
      rdata = 8'h00;
      if (ptr_q == 8'h00) rdata = config_q;
      if (ptr_q == 8'h01) rdata = {5'b0, alarm_any, overrun_q, valid_q};
      if (ptr_q == 8'h02) rdata = cnt_pub_q;
      for (int k = 0; k < NUM_CH; k++) begin
         if (ptr_q == 8'(3 + 2*k)) rdata = shadow_q[k][7:0];
         if (ptr_q == 8'(4 + 2*k)) rdata = 8'(shadow_q[k] >> 8);
      end
`ifdef ADC_THRESH_EN
      if (ptr_q == 8'h1F) rdata = 8'(alarm_q);
      for (int k = 0; k < NUM_CH; k++) begin
         if (ptr_q == 8'(32 + 2*k)) rdata = thresh_q[k][7:0];
         if (ptr_q == 8'(33 + 2*k)) rdata = 8'(thresh_q[k] >> 8);
      end
`endif
   end

   // Next state: I2C byte handling, capture/averaging and gated publishing.
   always_comb begin
      config_d  = config_q;
      ptr_d     = ptr_q;
      cnt_pub_d = cnt_pub_q;
      tx_buf_d  = tx_buf_q;
      nbyte_d   = nbyte_q;
      valid_d   = valid_q;
      run_wd_d  = run_wd_q;
      pkt_d     = pkt_q;
      raw_d     = raw_q;
      avg_d     = avg_q;
      acc_d     = acc_q;
      shadow_d  = shadow_q;
      new_avg   = 1'b0;

      rd_en      = tx_pls_q & bus.slave_asserted & bus.slave_in_tx_mode;
      wr_en      = rx_pls_q & bus.slave_asserted & ~bus.slave_in_tx_mode;
      wr_data_en = wr_en & (nbyte_q != 4'd0);
      csr_wr_d   = wr_data_en & (ptr_q == 8'h00);

      if (!bus.slave_asserted)              nbyte_d = 4'd0;
      else if (wr_en && nbyte_q != 4'hF)    nbyte_d = nbyte_q + 4'd1;

      if (wr_en && nbyte_q == 4'd0) ptr_d = bus.slave_rx_buffer;
      if (wr_data_en) begin
         ptr_d = ptr_q + 8'd1;
         if (ptr_q == 8'h00) begin
            config_d = bus.slave_rx_buffer;
            run_wd_d = bus.slave_rx_buffer[0];
         end
      end
      if (rd_en) begin
         tx_buf_d = rdata;
         ptr_d    = ptr_q + 8'd1;
      end

      for (int k = 0; k < NUM_CH; k++)
         if (bus.adc_valid && bus.adc_channel == CH_MAP[5*k +: 5]) raw_d[k] = bus.adc_data;

      // A channel missing from the packet keeps contributing its last raw value.
      if (bus.adc_valid && bus.adc_endofpacket) begin
         pkt_d = pkt_q + 1'b1;
         for (int k = 0; k < NUM_CH; k++) acc_d[k] = acc_q[k] + ACC_W'(raw_d[k]);
         if (pkt_d == PKT_N) begin
            new_avg = 1'b1;
            pkt_d   = '0;
            for (int k = 0; k < NUM_CH; k++) begin
               avg_d[k] = DATA_W'(acc_d[k] >> AVG_LOG2);
               acc_d[k] = '0;
            end
         end
      end

      blocked   = bus.slave_asserted & bus.slave_in_tx_mode;
      do_pub    = pending_q & ~blocked;
      pending_d = (pending_q & ~do_pub) | new_avg;
      overrun_d = (new_avg & pending_q & ~do_pub) |
                  (overrun_q & ~(wr_data_en & (ptr_q == 8'h01) & bus.slave_rx_buffer[1]));
      if (do_pub) begin
         shadow_d  = avg_q;
         valid_d   = 1'b1;
         cnt_pub_d = cnt_pub_q + 8'd1;
      end
   end

`ifdef ADC_THRESH_EN
   // Threshold registers and sticky alarms; a new alarm wins over a clear.
   always_comb begin
      thresh_d  = thresh_q;
      alarm_set = '0;
      alarm_clr = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         if (wr_data_en && ptr_q == 8'(32 + 2*k)) thresh_d[k][7:0] = bus.slave_rx_buffer;
         if (wr_data_en && ptr_q == 8'(33 + 2*k))
            thresh_d[k][DATA_W-1:8] = bus.slave_rx_buffer[DATA_W-9:0];
         if (do_pub && avg_q[k] > thresh_q[k]) alarm_set[k] = 1'b1;
      end
      if (wr_data_en && ptr_q == 8'h1F) alarm_clr = bus.slave_rx_buffer[NUM_CH-1:0];
      alarm_d = (alarm_q & ~alarm_clr) | alarm_set;
   end

   // Threshold/alarm state.
   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NUM_CH; k++) thresh_q[k] <= '1;
         alarm_q <= '0;
      end else begin
         thresh_q <= thresh_d;
         alarm_q  <= alarm_d;
      end
   end

   assign bus.alarm = alarm_q;
`endif

   // Main state registers.
   always_ff @(posedge clk_core or negedge reset_n) begin
      if (!reset_n) begin
         config_q  <= '0;
         ptr_q     <= '0;
         cnt_pub_q <= '0;
         tx_buf_q  <= '0;
         nbyte_q   <= '0;
         valid_q   <= 1'b0;
         overrun_q <= 1'b0;
         pending_q <= 1'b0;
         csr_wr_q  <= 1'b0;
         run_wd_q  <= 1'b0;
         pkt_q     <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            raw_q[k]    <= '0;
            avg_q[k]    <= '0;
            acc_q[k]    <= '0;
            shadow_q[k] <= '0;
         end
      end else begin
         config_q  <= config_d;
         ptr_q     <= ptr_d;
         cnt_pub_q <= cnt_pub_d;
         tx_buf_q  <= tx_buf_d;
         nbyte_q   <= nbyte_d;
         valid_q   <= valid_d;
         overrun_q <= overrun_d;
         pending_q <= pending_d;
         csr_wr_q  <= csr_wr_d;
         run_wd_q  <= run_wd_d;
         pkt_q     <= pkt_d;
         raw_q     <= raw_d;
         avg_q     <= avg_d;
         acc_q     <= acc_d;
         shadow_q  <= shadow_d;
      end
   end

   assign bus.slave_tx_buffer   = tx_buf_q;
   assign bus.seq_csr_address   = 1'b0;
   assign bus.seq_csr_write     = csr_wr_q;
   assign bus.seq_csr_writedata = {31'b0, run_wd_q};
   assign bus.adc_run           = config_q[0];
endmodule
